// File: rtl/deco_pkg.sv
// rtl/deco_pkg.sv - shared constants and helpers for the digit scan decoder
package deco_pkg;

    localparam int MAX_DIGITS       = 8;
    localparam int DEFAULT_PRESCALE = 100000;
    localparam int ACT_LOW          = 1;
    localparam int ACT_HIGH         = 0;

    // Width of a binary digit index, never below one bit
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/deco_binario_n.sv
// rtl/deco_binario_n.sv - combinational binary to one-hot decoder
module deco_binario_n
    import deco_pkg::*;
#(
    parameter int N     = MAX_DIGITS,
    parameter int SEL_W = sel_width(N)
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [N-1:0]     y
);

    // One bit per legal code; codes >= N match nothing and give all zeros
    always_comb begin
        y = '0;
        for (int i = 0; i < N; i++) begin
            y[i] = en && (sel == SEL_W'(i));
        end
    end

endmodule

// File: rtl/deco_scan_n.sv
// rtl/deco_scan_n.sv - multiplexed digit scanner with prescaler and blanking
module deco_scan_n
    import deco_pkg::*;
#(
    parameter int  N_DIGITS   = 4,
    parameter int  PRESCALE   = DEFAULT_PRESCALE,
    parameter int  ACTIVE_LOW = ACT_LOW,
    localparam int SEL_W      = sel_width(N_DIGITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [N_DIGITS-1:0] blank,
    output logic [SEL_W-1:0]    sel,
    output logic [N_DIGITS-1:0] onehot,
    output logic                tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [N_DIGITS-1:0] IDLE = (ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : '0;

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nx;
    logic [SEL_W-1:0]    sel_nx;
    logic                adv;
    logic [N_DIGITS-1:0] dec_y;
    logic [N_DIGITS-1:0] strobe;

    // Prescaler terminal count advances the slot; sel wraps explicitly so
    // non-power-of-two digit counts never reach unused codes
    always_comb begin
        adv    = en && (cnt == CNT_W'(PRESCALE - 1));
        cnt_nx = cnt;
        sel_nx = sel;
        if (en) begin
            cnt_nx = adv ? '0 : cnt + 1'b1;
        end
        if (adv) begin
            sel_nx = (sel == SEL_W'(N_DIGITS - 1)) ? '0 : sel + 1'b1;
        end
    end

    deco_binario_n #(
        .N     (N_DIGITS),
        .SEL_W (SEL_W)
    ) u_dec (
        .sel (sel_nx),
        .en  (en),
        .y   (dec_y)
    );

    // Blanking only masks the strobe; slot timing is left untouched
    always_comb begin
        strobe = dec_y & ~blank;
    end

    // Register slot state and the polarity-adjusted strobe together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            sel    <= '0;
            tick   <= 1'b0;
            onehot <= IDLE;
        end else begin
            cnt    <= cnt_nx;
            sel    <= sel_nx;
            tick   <= adv;
            onehot <= (ACTIVE_LOW != 0) ? ~strobe : strobe;
        end
    end

endmodule

// File: tb/tb_deco_scan_n.sv
// tb/tb_deco_scan_n.sv - self-checking bench for deco_scan_n
module tb_deco_scan_n;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] blank = 4'b0000;
    logic [1:0] sel;
    logic [3:0] onehot;
    logic       tick;

    logic       en2 = 1'b0;
    logic [2:0] blank2 = 3'b000;
    logic [1:0] sel2;
    logic [2:0] onehot2;
    logic       tick2;

    int n_cmp = 0;
    int n_bad = 0;

    int         m_cnt = 0;
    int         m_sel = 0;
    logic       m_tick = 1'b0;
    logic [3:0] m_oh = 4'hF;
    logic [6:0] exp_q[$];

    deco_scan_n #(.N_DIGITS(4), .PRESCALE(3), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .blank(blank),
        .sel(sel), .onehot(onehot), .tick(tick)
    );

    deco_scan_n #(.N_DIGITS(3), .PRESCALE(1), .ACTIVE_LOW(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .blank(blank2),
        .sel(sel2), .onehot(onehot2), .tick(tick2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_sel  = 0;
        m_tick = 1'b0;
        m_oh   = 4'hF;
    endtask

    // Drive one cycle of stimulus, push the expected result, compare after the edge
    task automatic step(input logic e, input logic [3:0] b);
        logic       adv;
        logic [3:0] act;
        logic [6:0] x;
        en    = e;
        blank = b;
        adv   = e && (m_cnt == 2);
        if (adv) m_sel = (m_sel + 1) % 4;
        if (e) m_cnt = adv ? 0 : m_cnt + 1;
        act    = (e && !b[m_sel]) ? (4'b0001 << m_sel) : 4'b0000;
        m_oh   = ~act;
        m_tick = adv;
        exp_q.push_back({m_sel[1:0], m_oh, m_tick});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            x = exp_q.pop_front();
            chk("sel", {30'd0, sel}, {30'd0, x[6:5]});
            chk("onehot", {28'd0, onehot}, {28'd0, x[4:1]});
            chk("tick", {31'd0, tick}, {31'd0, x[0]});
        end
    endtask

    initial begin
        #12;
        chk("rst_sel", {30'd0, sel}, 32'd0);
        chk("rst_onehot", {28'd0, onehot}, 32'hF);
        chk("rst_tick", {31'd0, tick}, 32'd0);
        chk("rst_onehot2", {29'd0, onehot2}, 32'd0);

        // release reset with en=1, first advance on the third enabled edge
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 4'b0000);
        chk("s1_onehot", {28'd0, onehot}, 32'hE);
        step(1'b1, 4'b0000);
        chk("s1_tick_hold", {31'd0, tick}, 32'd0);
        step(1'b1, 4'b0000);
        chk("s1_adv", {25'd0, sel, onehot, tick}, {25'd0, 2'd1, 4'b1101, 1'b1});

        // run through sel=3 and wrap
        for (int i = 0; i < 9; i++) step(1'b1, 4'b0000);
        chk("wrap", {25'd0, sel, onehot, tick}, {25'd0, 2'd0, 4'b1110, 1'b1});

        // en drop with cnt=1, then resume
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0000);
        chk("en_off", {26'd0, sel, onehot}, {26'd0, 2'd0, 4'b1111});
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0000);
        step(1'b1, 4'b0000);
        chk("resume_no_adv", {31'd0, tick}, 32'd0);
        step(1'b1, 4'b0000);
        chk("resume_adv", {25'd0, sel, onehot, tick}, {25'd0, 2'd1, 4'b1101, 1'b1});

        // blanking while sel=1 does not disturb timing
        step(1'b1, 4'b0010);
        chk("blank", {26'd0, sel, onehot}, {26'd0, 2'd1, 4'b1111});
        step(1'b1, 4'b0010);
        step(1'b1, 4'b0010);
        chk("blank_adv", {25'd0, sel, onehot, tick}, {25'd0, 2'd2, 4'b1011, 1'b1});

        // asynchronous reset mid-slot at sel=2
        step(1'b1, 4'b0000);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst", {25'd0, sel, onehot, tick}, {25'd0, 2'd0, 4'b1111, 1'b0});
        model_reset();
        @(posedge clk);
        #1;
        chk("arst_hold", {25'd0, sel, onehot, tick}, {25'd0, 2'd0, 4'b1111, 1'b0});
        #2;
        rst_n = 1'b1;

        // random en/blank traffic against the model
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
        end

        // second instance: N=3, PRESCALE=1, active-high
        #2;
        rst_n = 1'b0;
        #1;
        chk("d2_rst", {26'd0, sel2, onehot2, tick2}, 32'd0);
        #1;
        rst_n = 1'b1;
        en2   = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            int s;
            s = i % 3;
            @(posedge clk);
            #1;
            chk("d2_sel", {30'd0, sel2}, 32'(s));
            chk("d2_onehot", {29'd0, onehot2}, 32'(1 << s));
            chk("d2_tick", {31'd0, tick2}, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/deco_scan_n.md
DECO_SCAN_N -- requirements
Module: deco_scan_n

Interface
REQ-001 The block SHALL have the parameter N_DIGITS, default 4, giving the number of one-hot outputs; the legal range is 2..8.
REQ-002 The block SHALL have the parameter PRESCALE, default 100000, giving the number of enabled clocks per digit slot; the legal range is >=1.
REQ-003 The block SHALL have the parameter ACTIVE_LOW, default 1; when it is 1, the onehot output is inverted (an active digit drives 0).
REQ-004 The block SHALL derive the localparam SEL_W = max(1, $clog2(N_DIGITS)).
REQ-005 Port clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-007 Port en: input, 1 bit, scan enable.
REQ-008 Port blank: input, N_DIGITS bits, per-digit blanking mask.
REQ-009 Port sel: output, SEL_W bits, binary index of the current digit slot.
REQ-010 Port onehot: output, N_DIGITS bits, decoded digit strobe with polarity set by ACTIVE_LOW.
REQ-011 Port tick: output, 1 bit, one-cycle pulse marking the start of a new slot.

Function
REQ-012 The prescaler cnt SHALL count 0..PRESCALE-1, incrementing on each edge where en=1, and holding its value when en=0.
REQ-013 On an edge where en=1 and cnt==PRESCALE-1, the block SHALL set cnt to 0 and advance sel by one.
REQ-014 sel SHALL wrap from N_DIGITS-1 to 0, never taking codes >= N_DIGITS, including when N_DIGITS is not a power of two.
REQ-015 tick SHALL be registered and SHALL be 1 for exactly the cycle following an advance edge, so it is aligned with the new sel value.
REQ-016 When PRESCALE==1 and en=1, the block SHALL advance sel every cycle and hold tick continuously at 1.
REQ-017 onehot SHALL be registered and SHALL change on the same edge as sel, carrying the decode of the post-edge sel value.
REQ-018 The active bit of onehot SHALL be asserted only if en=1 and blank[next sel]=0 at that edge; otherwise all bits of onehot SHALL be inactive.
REQ-019 Blanking SHALL NOT skip slots: sel and tick timing SHALL be independent of blank, so that brightness stays uniform.
REQ-020 Changes to en or blank SHALL be reflected on onehot exactly one clock later.
REQ-021 When en falls mid-slot, cnt and sel SHALL hold, and the slot SHALL resume with its remaining count when en rises again.
REQ-022 At no time SHALL more than one bit of onehot be active.

Reset
REQ-023 While rst_n=0, independent of clk, the block SHALL force cnt=0, sel=0, tick=0, and every bit of onehot inactive (all 1s if ACTIVE_LOW=1, else all 0s).
REQ-024 After rst_n rises, the first advance edge SHALL be the PRESCALE-th enabled edge.
REQ-025 Assertion of reset mid-slot SHALL discard the partial count, with no tick generated.

Structure
REQ-026 Package deco_pkg SHALL hold MAX_DIGITS=8, DEFAULT_PRESCALE=100000, and the ACT_LOW/ACT_HIGH polarity constants.
REQ-027 The block SHALL instantiate one sub-module, deco_binario_n: a parametrised combinational binary-to-one-hot decoder with inputs sel[SEL_W] and en, and active-high output y[N].
REQ-028 deco_binario_n SHALL output 0 for codes >= N.
REQ-029 Blank gating, polarity inversion and registering SHALL be implemented in deco_scan_n, not in deco_binario_n.

Verification (N_DIGITS=4, PRESCALE=3, ACTIVE_LOW=1 unless stated)
REQ-030 Scenario: release reset with en=1, blank=0 -> onehot=1110 and sel=0 for 3 cycles, then sel=1, onehot=1101 and tick=1 for one cycle.
REQ-031 Scenario: run through sel=3 (onehot=0111) -> the next advance gives sel=0, onehot=1110, tick=1.
REQ-032 Scenario: drop en with cnt=1 for 5 cycles -> onehot=1111 one cycle later with sel held; raise en -> the advance occurs 2 enabled edges later.
REQ-033 Scenario: blank=0010 while sel=1 -> onehot=1111 one cycle later, and sel still advances to 2 on schedule with onehot=1011.
REQ-034 Scenario: assert rst_n=0 asynchronously mid-slot at sel=2 -> sel=0, tick=0 and onehot=1111 immediately, without waiting for a clock edge.
REQ-035 Scenario: N_DIGITS=3, PRESCALE=1, ACTIVE_LOW=0 -> sel sequence 0,1,2,0 every cycle, onehot sequence 001,010,100,001, tick held at 1.
